// File: rtl/fmap_capture.sv
// Frame capture buffer for the feature-map pixel stream: stores one raster frame,
// tracks count and sum, flags completion/gap/overrun, and serves random-access reads.
module fmap_capture #(
  parameter int I_F_BW       = 8,
  parameter int IX           = 28,
  parameter int IY           = 28,
  parameter int TOTAL_PIXELS = IX * IY,
  parameter int GAP_MAX      = 16
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [I_F_BW-1:0]                         i_pixel,
  input  logic                                      i_in_valid,
  input  logic                                      i_release,
  input  logic                                      i_rd_en,
  input  logic [$clog2(TOTAL_PIXELS)-1:0]           i_rd_addr,
  output logic [I_F_BW-1:0]                         o_rd_data,
  output logic                                      o_rd_valid,
  output logic                                      o_busy,
  output logic                                      o_full,
  output logic                                      o_frame_done,
  output logic                                      o_err_gap,
  output logic                                      o_err_overrun,
  output logic [$clog2(TOTAL_PIXELS+1)-1:0]         o_pix_cnt,
  output logic [I_F_BW+$clog2(TOTAL_PIXELS)-1:0]    o_sum
);

  localparam int AW = $clog2(TOTAL_PIXELS);
  localparam int CW = $clog2(TOTAL_PIXELS + 1);
  localparam int SW = I_F_BW + AW;
  localparam int GW = (GAP_MAX > 1) ? $clog2(GAP_MAX + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t              state;
  logic [GW-1:0]       gap_cnt;
  logic [I_F_BW-1:0]   mem [TOTAL_PIXELS];

  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic                last_beat;
  logic                gap_hit;
  logic                rd_in_range;

  // Widened add keeps the accumulator exact for a full frame of max-value pixels.
  function automatic logic [SW-1:0] acc_add(input logic [SW-1:0] acc,
                                            input logic [I_F_BW-1:0] pix);
    return acc + SW'(pix);
  endfunction

  assign wr_en       = i_in_valid && (state != FULL) && !reset;
  assign wr_addr     = (state == RECV) ? o_pix_cnt[AW-1:0] : '0;
  assign last_beat   = (o_pix_cnt == CW'(TOTAL_PIXELS - 1));
  assign gap_hit     = (GAP_MAX != 0) && (gap_cnt == GW'(GAP_MAX - 1));
  assign rd_in_range = ({1'b0, i_rd_addr} < (AW + 1)'(TOTAL_PIXELS));

  // Buffer is deliberately left out of reset; its contents survive a reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= i_pixel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        o_rd_data <= rd_in_range ? mem[i_rd_addr] : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      gap_cnt       <= '0;
      o_busy        <= 1'b0;
      o_full        <= 1'b0;
      o_frame_done  <= 1'b0;
      o_err_gap     <= 1'b0;
      o_err_overrun <= 1'b0;
      o_pix_cnt     <= '0;
      o_sum         <= '0;
    end else begin
      o_frame_done <= 1'b0;
      o_err_gap    <= 1'b0;
      case (state)
        IDLE: begin
          if (i_in_valid) begin
            state     <= RECV;
            o_busy    <= 1'b1;
            o_pix_cnt <= CW'(1);
            o_sum     <= SW'(i_pixel);
            gap_cnt   <= '0;
          end
        end
        RECV: begin
          if (i_in_valid) begin
            o_pix_cnt <= o_pix_cnt + CW'(1);
            o_sum     <= acc_add(o_sum, i_pixel);
            gap_cnt   <= '0;
            if (last_beat) begin
              state        <= FULL;
              o_busy       <= 1'b0;
              o_full       <= 1'b1;
              o_frame_done <= 1'b1;
            end
          end else if (gap_hit) begin
            // Stream stalled too long: drop the partial frame and re-arm.
            state     <= IDLE;
            o_busy    <= 1'b0;
            o_err_gap <= 1'b1;
            o_pix_cnt <= '0;
            o_sum     <= '0;
            gap_cnt   <= '0;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        FULL: begin
          if (i_release) begin
            // A beat coinciding with release is still an overrun.
            state         <= IDLE;
            o_full        <= 1'b0;
            o_pix_cnt     <= '0;
            o_err_overrun <= i_in_valid;
          end else if (i_in_valid) begin
            o_err_overrun <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
          o_full <= 1'b0;
        end
      endcase
    end
  end

endmodule
